// File: rtl/wb_arbiter.sv
// wb_arbiter: two-channel round-robin register write arbiter with pending-write scoreboard
// Ports: clk/rst clock and sync active-high reset; a_*/b_* valid/ready write channels (ALU, load unit);
// alloc_valid/alloc_addr mark a destination pending; flush clears all pending marks;
// we/waddr/wdata registered regfile write port; q_addr1/q_addr2 -> q_busy1/q_busy2 pending status.
module wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    input  logic              alloc_valid,
    input  logic [ADDR_W-1:0] alloc_addr,
    input  logic              flush,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] q_addr1,
    input  logic [ADDR_W-1:0] q_addr2,
    output logic              q_busy1,
    output logic              q_busy2
);
    localparam int N = 2 ** ADDR_W;
    logic              last_b;
    logic              acc;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_data;
    logic [N-1:0]      busy;
    logic [N-1:0]      busy_nxt;
    // last_b records the winner of the most recent contested cycle; the other channel wins the next one
    always_comb begin
        a_ready  = !rst && a_valid && (!b_valid || last_b);
        b_ready  = !rst && b_valid && (!a_valid || !last_b);
        acc      = a_ready || b_ready;
        acc_addr = a_ready ? a_addr : b_addr;
        acc_data = a_ready ? a_data : b_data;
        busy_nxt = busy;
        if (acc) busy_nxt[acc_addr] = 1'b0;
        if (alloc_valid) busy_nxt[alloc_addr] = 1'b1;
        if (flush) busy_nxt = '0;
        busy_nxt[0] = 1'b0;
    end
    assign q_busy1 = busy[q_addr1];
    assign q_busy2 = busy[q_addr2];
    always_ff @(posedge clk) begin
        if (rst) begin
            last_b <= 1'b1;
            we     <= 1'b0;
            waddr  <= '0;
            wdata  <= '0;
            busy   <= '0;
        end else begin
            if (a_valid && b_valid) last_b <= b_ready;
            we   <= acc && (acc_addr != '0);
            busy <= busy_nxt;
            if (acc) begin
                waddr <= acc_addr;
                wdata <= acc_data;
            end
        end
    end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning register address width; 2**ADDR_W registers.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port a_valid / a_ready  input / output  1 / 1  channel A (ALU) write request and accept.
REQ-006 SHALL have port a_addr / a_data  input  ADDR_W / DATA_W  channel A destination and value.
REQ-007 SHALL have port b_valid / b_ready  input / output  1 / 1  channel B (load unit) write request and accept.
REQ-008 SHALL have port b_addr / b_data  input  ADDR_W / DATA_W  channel B destination and value.
REQ-009 SHALL have port alloc_valid / alloc_addr  input  1 / ADDR_W  issue marks a destination register pending.
REQ-010 SHALL have port flush  input  1  clears all pending marks.
REQ-011 SHALL have port we / waddr / wdata  output  1 / ADDR_W / DATA_W  registered regfile write port.
REQ-012 SHALL have port q_addr1 / q_addr2  input  ADDR_W  scoreboard query addresses.
REQ-013 SHALL have port q_busy1 / q_busy2  output  1  pending status of q_addr1 / q_addr2.

Function
REQ-014 SHALL accept at most one channel per cycle; transfer occurs when valid and ready are both high.
REQ-015 SHALL grant the sole requesting channel when only one valid is high.
REQ-016 SHALL, when both valid, grant the channel opposite the round-robin pointer's last winner.
REQ-017 SHALL update the pointer only on contested cycles, recording the granted channel.
REQ-018 SHALL make a_ready/b_ready combinational from valids and pointer; ready is never high without its valid.
REQ-019 SHALL register the accepted transfer: we=1, waddr, wdata appear the cycle after acceptance (latency 1).
REQ-020 SHALL drive we=0 in a cycle following no acceptance; waddr/wdata hold their previous values.
REQ-021 SHALL accept writes to address 0 (ready high) but drive we=0 for them.
REQ-022 SHALL hold a 2**ADDR_W-bit busy vector; bit 0 is constant 0.
REQ-023 SHALL set busy[alloc_addr] at the clock edge when alloc_valid=1 and alloc_addr!=0.
REQ-024 SHALL clear busy[addr] at the edge on which a transfer to addr is accepted.
REQ-025 SHALL, on a simultaneous set and clear of the same address, leave the bit set.
REQ-026 SHALL, on flush, clear all busy bits, including any same-cycle set; flush does not block arbitration or the write port.
REQ-027 SHALL compute q_busy1/q_busy2 combinationally from the registered busy vector, excluding same-cycle updates.
REQ-028 SHALL keep we high for at most one cycle per accepted transfer; no write is duplicated or dropped.

Reset
REQ-029 SHALL, while rst=1 at an edge, set we=0, waddr=0, wdata=0, all busy bits=0, and the pointer so that channel A wins the next contested cycle.
REQ-030 SHALL drive a_ready=b_ready=0 combinationally while rst=1; no transfer, allocation or flush takes effect.
REQ-031 SHALL make reset override every other input, including mid-contention and alloc/flush in the same cycle.

Verification
REQ-032 SHALL cover: after reset, a_valid=1 a_addr=3 a_data=0x11, b_valid=1 b_addr=4 b_data=0x22 held -> cycle1 a_ready=1; next edge we=1 waddr=3 wdata=0x11; cycle2 b_ready=1; next edge waddr=4 wdata=0x22; then alternation continues.
REQ-033 SHALL cover: alloc_valid=1 alloc_addr=7 for one edge, q_addr1=7 -> q_busy1=1 next cycle; b transfer to 7 accepted -> q_busy1=0 after that edge.
REQ-034 SHALL cover: the same edge carries alloc_addr=9 and an accepted write to 9 -> busy[9]=1 afterwards; q_busy2 with q_addr2=9 reads 1.
REQ-035 SHALL cover: a_valid=1 a_addr=0 a_data=0xFF -> a_ready=1; following cycle we=0; q_busy1 with q_addr1=0 always 0.
REQ-036 SHALL cover: busy bits 5 and 6 set, flush=1 together with alloc_addr=8 -> all busy bits 0 after the edge.
REQ-037 SHALL cover: rst=1 asserted while both valids are high and busy[5]=1 -> readies 0 that cycle, we=0 and busy all 0 after the edge; the first contested grant after reset goes to A.
